// File: rtl/sum16_ctrl_pkg.sv
// sum16_ctrl_pkg: shared FSM encoding and default operand size for sum16_ctrl.
package sum16_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int NIBBLES_DEF = 4;
endpackage

// File: rtl/sum4.sv
// sum4: 4-bit full adder with carry in and carry out.
module sum4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0, ci};
endmodule

// File: rtl/sum16_ctrl.sv
// sum16_ctrl: nibble-serial adder that reuses one sum4 over NIBBLES cycles.
module sum16_ctrl
  import sum16_ctrl_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 c_in,
  output logic [4*NIBBLES-1:0] S,
  output logic                 c_out,
  output logic                 ovf,
  output logic                 busy,
  output logic                 done
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [CW+1:0] idx;
  logic [W-1:0] ra, rb;
  logic carry, last, nco;
  logic [3:0] nsum;
  assign idx  = {cnt, 2'b00};
  assign last = cnt == CW'(NIBBLES - 1);
  sum4 u_add (.a(ra[idx +: 4]), .b(rb[idx +: 4]), .ci(carry), .s(nsum), .co(nco));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt  = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
    busy = state != IDLE;
    done = state == DONE;
  end
  // Operands are latched at accept so later input changes cannot disturb the result.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ra    <= '0;
      rb    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
    end else if (state == IDLE && start) begin
      ra    <= a;
      rb    <= b;
      carry <= c_in;
      cnt   <= '0;
    end else if (state == RUN) begin
      S[idx +: 4] <= nsum;
      carry       <= nco;
      cnt         <= cnt + 1'b1;
    end
  assign c_out = carry;
  assign ovf   = (ra[W-1] == rb[W-1]) && (S[W-1] != ra[W-1]);
endmodule

// File: tb/tb_sum16_ctrl.sv
// tb_sum16_ctrl: directed table, corner sequences and random ops against an integer model.
module tb_sum16_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, c_in = 1'b0;
  logic [15:0] a = '0, b = '0, S;
  logic c_out, ovf, busy, done;
  int n_chk = 0, n_err = 0;

  sum16_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c_in(c_in),
    .S(S), .c_out(c_out), .ovf(ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b;
    logic        ci;
    logic [15:0] s;
    logic        co, ov;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned and signed integer sums, range-checked.
  function automatic logic [17:0] ref_add(input logic [15:0] x, input logic [15:0] y, input logic ci);
    int u, sg;
    logic co, ov;
    u  = int'(x) + int'(y) + int'(ci);
    sg = int'($signed(x)) + int'($signed(y)) + int'(ci);
    co = u > 65535;
    ov = sg > 32767 || sg < -32768;
    return {ov, co, u[15:0]};
  endfunction

  task automatic op_check(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vc, input logic [15:0] es, input logic eco, input logic eov);
    int lat;
    bit got, d;
    logic [15:0] s_seen;
    logic co_seen, ov_seen;
    @(negedge clk);
    start = 1'b1; a = va; b = vb; c_in = vc;
    @(posedge clk);
    #1 start = 1'b0; a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
    chk({tag, " busy_run"}, 32'(busy), 32'd1);
    lat = 0; got = 0; s_seen = '0; co_seen = 0; ov_seen = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      d = done; s_seen = S; co_seen = c_out; ov_seen = ovf;
      @(posedge clk);
      lat++;
      got = d;
    end
    chk({tag, " latency"}, 32'(lat), 32'd5);
    chk({tag, " S"}, 32'(s_seen), 32'(es));
    chk({tag, " c_out"}, 32'(co_seen), 32'(eco));
    chk({tag, " ovf"}, 32'(ov_seen), 32'(eov));
    @(negedge clk);
    chk({tag, " done_1cyc"}, 32'(done), 32'd0);
    chk({tag, " S_hold"}, 32'(S), 32'(es));
  endtask

  vec_t tbl[7];
  vec_t hv[3];

  initial begin
    logic [17:0] r;
    logic [15:0] ra, rb;
    logic rc;
    int pulses, prev, ndone;
    logic [15:0] s_done;
    tbl[0] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[5] = '{16'h0005, 16'h000A, 1'b0, 16'h000F, 1'b0, 1'b0};
    tbl[6] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};

    #12;
    chk("rst S", 32'(S), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst c_out", 32'(c_out), 32'd0);
    chk("rst ovf", 32'(ovf), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      op_check($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].s, tbl[i].co, tbl[i].ov);

    // A start pulsed mid-operation must be ignored.
    @(negedge clk);
    start = 1'b1; a = 16'h0F0F; b = 16'hF0F0; c_in = 1'b0;
    ndone = 0; s_done = '0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 1) begin start = 1'b1; a = 16'h1234; b = 16'h1111; end
      else start = 1'b0;
      if (done) begin ndone++; s_done = S; chk("ign c_out", 32'(c_out), 32'd0); end
    end
    chk("ign pulses", 32'(ndone), 32'd1);
    chk("ign S", 32'(s_done), 32'hFFFF);

    // Asynchronous reset while nibble 2 is in progress.
    @(negedge clk);
    start = 1'b1; a = 16'h1234; b = 16'h0F0F; c_in = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort S", 32'(S), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort c_out", 32'(c_out), 32'd0);
    ndone = 0;
    repeat (3) begin @(negedge clk); if (done) ndone++; end
    rst_n = 1'b1;
    repeat (6) begin @(negedge clk); if (done) ndone++; end
    chk("abort no_done", 32'(ndone), 32'd0);
    op_check("post_rst", 16'h0005, 16'h000A, 1'b0, 16'h000F, 1'b0, 1'b0);

    // Start held high: back-to-back operations every 6 cycles.
    hv[0] = '{16'h1111, 16'h2222, 1'b0, 16'h0, 1'b0, 1'b0};
    hv[1] = '{16'hFFF0, 16'h0020, 1'b1, 16'h0, 1'b0, 1'b0};
    hv[2] = '{16'h4000, 16'h4000, 1'b0, 16'h0, 1'b0, 1'b0};
    @(negedge clk);
    start = 1'b1; a = hv[0].a; b = hv[0].b; c_in = hv[0].ci;
    pulses = 0; prev = 0;
    for (int c = 1; c <= 40 && pulses < 3; c++) begin
      @(negedge clk);
      if (done) begin
        r = ref_add(hv[pulses].a, hv[pulses].b, hv[pulses].ci);
        chk($sformatf("held%0d S", pulses), 32'(S), 32'(r[15:0]));
        chk($sformatf("held%0d flags", pulses), 32'({ovf, c_out}), 32'(r[17:16]));
        if (pulses > 0) chk($sformatf("held%0d spacing", pulses), 32'(c - prev), 32'd6);
        prev = c;
        pulses++;
        if (pulses < 3) begin a = hv[pulses].a; b = hv[pulses].b; c_in = hv[pulses].ci; end
        else start = 1'b0;
      end
    end
    start = 1'b0;
    chk("held pulses", 32'(pulses), 32'd3);
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      if (i % 8 == 0) rb = 16'(17'h10000 - 17'(ra));
      r = ref_add(ra, rb, rc);
      op_check($sformatf("rnd%0d", i), ra, rb, rc, r[15:0], r[16], r[17]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
